// File: rtl/cnn_layer_accel_weight_loader.sv
// rtl/cnn_layer_accel_weight_loader.sv - unpacks config FIFO words into weight table writes
//
// Purpose: takes packed weight words from the layer-config FIFO and writes them,
// one weight per cycle, into the convolution-engine weight table. Kernel-major
// order, C_KERNEL_SIZE weights per kernel, kernels 0..num_kernels.
//
// Ports:
//   clk, rst                    core clock, asynchronous active-high reset
//   job_accept, num_kernels     start/restart a load; num_kernels = last kernel index
//   cfg_word_valid/_ready/cfg_word  config FIFO handshake, lane 0 in the LSBs
//   config_mode, wht_config_wren, wht_config_data  weight table write interface
//   load_busy, load_done        status to the job sequencer

module cnn_layer_accel_weight_loader #(
  parameter int C_WORD_WIDTH       = 64,
  parameter int C_WEIGHT_WIDTH     = 16,
  parameter int C_KERNEL_SIZE      = 9,
  parameter int C_CLG2_MAX_KERNELS = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          job_accept,
  input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
  input  logic                          cfg_word_valid,
  input  logic [C_WORD_WIDTH-1:0]       cfg_word,
  output logic                          cfg_word_ready,
  output logic                          config_mode,
  output logic                          wht_config_wren,
  output logic [C_WEIGHT_WIDTH-1:0]     wht_config_data,
  output logic                          load_busy,
  output logic                          load_done
);

  localparam int L    = C_WORD_WIDTH / C_WEIGHT_WIDTH;
  localparam int LW   = (L > 1) ? $clog2(L) : 1;
  localparam int MAXN = (2 ** C_CLG2_MAX_KERNELS) * C_KERNEL_SIZE;
  localparam int CW   = $clog2(MAXN + 1);
  localparam int KW   = (C_KERNEL_SIZE > 1) ? $clog2(C_KERNEL_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [C_WORD_WIDTH-1:0]   r_word;      // remaining lanes, next lane in the LSBs
  logic [C_WEIGHT_WIDTH-1:0] r_data;
  logic                      r_held;      // a weight is being written this cycle
  logic [LW-1:0]             r_lane;
  logic [CW-1:0]             r_wcnt;      // index of the weight currently written
  logic [CW-1:0]             r_last_idx;  // N-1, latched on job_accept
  logic [KW-1:0]             r_kcnt;
  logic [C_CLG2_MAX_KERNELS-1:0] r_kidx;
  logic                      r_cfg_mode;
  logic                      r_done;

  logic                      w_ready;
  logic                      w_take;
  logic                      w_lane_end;
  logic                      w_last_wr;
  logic [CW-1:0]             w_last_idx;

  assign w_last_idx = CW'(num_kernels) * CW'(C_KERNEL_SIZE) + CW'(C_KERNEL_SIZE - 1);
  assign w_lane_end = (r_lane == LW'(L - 1));
  assign w_last_wr  = r_held && (r_wcnt == r_last_idx);
  assign w_take     = cfg_word_valid && w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // job_accept also gates ready: a word taken in the restart cycle would be
  // thrown away with the aborted load and lost from the FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: if (job_accept) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (!job_accept) w_ready = !r_held || (w_lane_end && !w_last_wr);
        if (job_accept)     w_state_nxt = S_LOAD;
        else if (w_last_wr) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = job_accept ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= '0;
      r_data     <= '0;
      r_held     <= 1'b0;
      r_lane     <= '0;
      r_wcnt     <= '0;
      r_last_idx <= '0;
      r_kcnt     <= '0;
      r_kidx     <= '0;
      r_cfg_mode <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cfg_mode <= (w_state_nxt == S_LOAD);
      r_done     <= (r_state == S_LOAD) && !job_accept && w_last_wr;
      if (job_accept) begin
        r_last_idx <= w_last_idx;
        r_word     <= '0;
        r_held     <= 1'b0;
        r_lane     <= '0;
        r_wcnt     <= '0;
        r_kcnt     <= '0;
        r_kidx     <= '0;
      end else begin
        if (r_held) begin
          // Mirrors the weight table's kernel_count / kernel_group stepping.
          if (r_kcnt == KW'(C_KERNEL_SIZE - 1)) begin
            r_kcnt <= '0;
            r_kidx <= r_kidx + 1'b1;
          end else begin
            r_kcnt <= r_kcnt + 1'b1;
          end
          if (!w_last_wr) r_wcnt <= r_wcnt + CW'(1);
        end
        if (w_take) begin
          r_word <= cfg_word >> C_WEIGHT_WIDTH;
          r_data <= cfg_word[C_WEIGHT_WIDTH-1:0];
          r_lane <= '0;
          r_held <= 1'b1;
        end else if (r_held) begin
          // Last write drops the word, including any padding lanes above it.
          if (w_last_wr || w_lane_end) begin
            r_held <= 1'b0;
          end else begin
            r_lane <= r_lane + LW'(1);
            r_data <= r_word[C_WEIGHT_WIDTH-1:0];
            r_word <= r_word >> C_WEIGHT_WIDTH;
          end
        end
      end
    end
  end

  assign cfg_word_ready  = w_ready;
  assign config_mode     = r_cfg_mode;
  assign load_busy       = r_cfg_mode;
  // The table clears its counters in the job_accept cycle; no write may land there.
  assign wht_config_wren = r_held && !job_accept;
  assign wht_config_data = r_data;
  assign load_done       = r_done;

endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
// tb/tb_cnn_layer_accel_weight_loader.sv - scoreboard bench for the weight loader

module tb_cnn_layer_accel_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_accept;
  logic [5:0]  num_kernels;
  logic        cfg_word_valid;
  logic [63:0] cfg_word;
  logic        cfg_word_ready;
  logic        config_mode;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic        load_busy;
  logic        load_done;

  cnn_layer_accel_weight_loader dut (
    .clk             (clk),
    .rst             (rst),
    .job_accept      (job_accept),
    .num_kernels     (num_kernels),
    .cfg_word_valid  (cfg_word_valid),
    .cfg_word        (cfg_word),
    .cfg_word_ready  (cfg_word_ready),
    .config_mode     (config_mode),
    .wht_config_wren (wht_config_wren),
    .wht_config_data (wht_config_data),
    .load_busy       (load_busy),
    .load_done       (load_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [63:0] fifo_q[$];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          hs_cnt = 0;
  int          first_wr = -1;
  int          last_wr = -1;
  int          bub_after = 0;
  int          bub_lo = -1;
  int          bub_hi = -1;
  logic        prev_wren = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pops the scoreboard; load_done is checked against the write stream.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wren = 1'b0;
      end else begin
        if (wht_config_wren) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got data %0h expected no write", wht_config_data);
          end else begin
            check("wr_data", 32'(wht_config_data), 32'(exp_q.pop_front()));
          end
          check("wr_config_mode", 32'(config_mode), 32'd1);
          wr_cnt++;
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
        end
        if (load_done) begin
          done_cnt++;
          check("done_after_last_write", 32'(prev_wren), 32'd1);
          check("done_config_mode", 32'(config_mode), 32'd0);
          check("done_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        end
        prev_wren = wht_config_wren;
      end
    end
  end

  // FIFO model: presents fifo_q[0]; pops on a handshake; optional bubble window.
  initial begin
    cfg_word_valid = 1'b0;
    cfg_word       = '0;
    forever begin
      @(negedge clk);
      if (!rst && cfg_word_valid && cfg_word_ready) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        hs_cnt++;
        if (hs_cnt == bub_after) begin
          bub_lo = cyc + 4;
          bub_hi = cyc + 8;
        end
      end
      @(posedge clk);
      #2;
      cfg_word_valid = (fifo_q.size() > 0) && !(cyc >= bub_lo && cyc <= bub_hi);
      cfg_word       = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
    end
  end

  // Weight k of a job tagged t is {t[5:0], k[9:0]}; padding lanes are FFFF.
  task automatic start_job(input int nk, input int tag, input int bubble);
    int          n;
    int          nw;
    logic [63:0] w;
    logic [15:0] v;
    @(posedge clk);
    #1;
    num_kernels = 6'(nk);
    job_accept  = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    wr_cnt    = 0;
    done_cnt  = 0;
    hs_cnt    = 0;
    first_wr  = -1;
    bub_after = bubble;
    bub_lo    = -1;
    bub_hi    = -1;
    n  = (nk + 1) * 9;
    nw = (n + 3) / 4;
    for (int i = 0; i <= nw; i++) begin
      for (int j = 0; j < 4; j++) begin
        v = (4 * i + j < n) ? {6'(tag), 10'(4 * i + j)} : 16'hFFFF;
        w[16*j +: 16] = v;
        if (4 * i + j < n) exp_q.push_back(v);
      end
      fifo_q.push_back(w);
    end
    @(negedge clk);
    check("accept_cycle_wren", 32'(wht_config_wren), 32'd0);
    @(posedge clk);
    #1;
    job_accept = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (wr_cnt < n && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("wait_writes_timeout", 32'(wr_cnt >= n), 32'd1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("wait_done_timeout", 32'(done_cnt > 0), 32'd1);
    repeat (12) @(negedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(cfg_word_ready), 32'd0);
    check({tag, "_config_mode"}, 32'(config_mode), 32'd0);
    check({tag, "_wren"}, 32'(wht_config_wren), 32'd0);
    check({tag, "_busy"}, 32'(load_busy), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    job_accept  = 1'b0;
    num_kernels = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_data", 32'(wht_config_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single kernel, 3 words, lanes 1-3 of word 3 are padding
    start_job(0, 1, 0);
    wait_done();
    check("s1_writes", 32'(wr_cnt), 32'd9);
    check("s1_handshakes", 32'(hs_cnt), 32'd3);
    check("s1_done_count", 32'(done_cnt), 32'd1);
    check("s1_span", 32'(last_wr - first_wr + 1), 32'd9);
    check("s1_extra_word_left", 32'(fifo_q.size()), 32'd1);
    check_idle_outputs("s1_idle");

    // 2: four kernels back-to-back
    start_job(3, 2, 0);
    wait_done();
    check("s2_writes", 32'(wr_cnt), 32'd36);
    check("s2_handshakes", 32'(hs_cnt), 32'd9);
    check("s2_span", 32'(last_wr - first_wr + 1), 32'd36);
    check("s2_done_count", 32'(done_cnt), 32'd1);

    // 3: five-cycle FIFO bubble after word 4
    start_job(3, 3, 4);
    wait_done();
    check("s3_writes", 32'(wr_cnt), 32'd36);
    check("s3_span", 32'(last_wr - first_wr + 1), 32'd41);
    check("s3_done_count", 32'(done_cnt), 32'd1);

    // 4: restart with num_kernels=1 during the 12th write
    start_job(3, 4, 0);
    wait_wr(11);
    check("s4_no_done_before_restart", 32'(done_cnt), 32'd0);
    start_job(1, 5, 0);
    wait_done();
    check("s4_writes", 32'(wr_cnt), 32'd18);
    check("s4_handshakes", 32'(hs_cnt), 32'd5);
    check("s4_done_count", 32'(done_cnt), 32'd1);

    // 5: asynchronous reset after 7 writes
    start_job(3, 6, 0);
    wait_wr(7);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outputs("s5_rst");
    check("s5_rst_data", 32'(wht_config_data), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s5_idle_ready", 32'(cfg_word_ready), 32'd0);
    end
    check("s5_valid_presented", 32'(cfg_word_valid), 32'd1);
    check("s5_no_handshake", 32'(hs_cnt), 32'd0);

    // 6: maximum size
    start_job(63, 7, 0);
    wait_done();
    check("s6_writes", 32'(wr_cnt), 32'd576);
    check("s6_handshakes", 32'(hs_cnt), 32'd144);
    check("s6_done_count", 32'(done_cnt), 32'd1);
    check("s6_span", 32'(last_wr - first_wr + 1), 32'd576);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
